alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised successor to the CPU31 combinational ALU. It keeps the 4-bit `aluc` single-cycle datapath with explicit flag rules for every opcode, and adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with a start/busy/done handshake and HI/LO result registers. It sits in the execute stage. The controller stalls on `busy` and reads `hi`/`lo` after `done`.

## Interface
- `WIDTH`, 32: datapath width, ≥ 8, even.
- `SHW`, $clog2(WIDTH): shift-amount compare width (internal, derived).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `a`  in  WIDTH  operand A; shift amount for shifts.
- `b`  in  WIDTH  operand B.
- `aluc`  in  4  ALU opcode (combinational path).
- `start`  in  1  request MDU operation, sampled on `clk`.
- `md_op`  in  2  MDU opcode: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `r`  out  WIDTH  ALU result.
- `zero`, `carry`, `negative`, `overflow`  out  1 each  ALU flags.
- `hi`, `lo`  out  WIDTH  MDU result: product high/low, or remainder/quotient.
- `busy`  out  1  MDU operating; new `start` ignored.
- `done`  out  1  one-cycle pulse, `hi`/`lo` valid.
- `div_zero`  out  1  last completed divide had `b`==0; held until next accept.

## Operation
- **ALU path** is purely combinational. Opcodes:
  - 0000 ADDU, 0010 ADD, 0001 SUBU, 0011 SUB.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: `r`={b[WIDTH/2-1:0], zeros}.
  - 1011 SLT, 1010 SLTU.
  - 1100 SRA, 1101 SRL, 111x SLL. Shift amount is the full value of `a`.
  - Undefined opcodes give `r`=0.
- **carry**:
  - ADDU: carry-out.
  - SUBU and SLTU: a<b unsigned.
  - SUB: a<b signed.
  - Shifts: last bit shifted out. 0 if a==0. If a≥WIDTH: SRA gives b[MSB], SRL/SLL give 0.
  - All other opcodes: 0. There is no latched hold.
- **overflow**: signed overflow for ADD and SUB. 0 otherwise.
- **negative**: for SLT, the signed a<b result. Otherwise r[MSB].
- **zero**: for SLT/SLTU, a==b. Otherwise r==0.
- **MDU** is an FSM with states IDLE, MUL, DIV, FIX.
  - Accept: in IDLE, `start`=1 latches `a`, `b`, `md_op` and goes to MUL or DIV. `start` outside IDLE is ignored.
  - Signed ops take operand magnitudes. Result signs are recorded for FIX.
  - MUL: radix-2 shift-add, one bit per cycle, WIDTH cycles, then FIX.
  - DIV: restoring divide, one bit per cycle, WIDTH cycles, then FIX.
  - FIX: applies signs, writes `hi`/`lo`, pulses `done`, returns to IDLE.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend. MIN/−1 gives lo=MIN, hi=0.
  - Divide by zero skips iteration and goes straight to FIX: lo=all-ones, hi=a, `div_zero`=1.
  - `hi`/`lo` hold their value until the next FIX. They are not cleared on accept.

## Timing
- **Reset** (asynchronous, while `rst_n`=0): FSM=IDLE; `hi`=`lo`=0; `busy`=`done`=`div_zero`=0; all internal registers 0. Reset mid-operation aborts with no `done`.
- **Accept** edge E0: `busy`=1 from just after E0.
- **Iteration** on edges E1..E_WIDTH. FIX on E_(WIDTH+1): `done`=1 and `busy`=0 for exactly the following cycle. Latency is WIDTH+1 cycles (33 at WIDTH=32).
- **Divide by zero**: FIX at E1, latency 1.
- **Back-to-back**: `start` high in the cycle where `done`=1 is accepted (FSM is IDLE), so throughput is one op per WIDTH+2 cycles.
- **ALU path** has zero latency and is independent of MDU state.

## Structure
- Package `alu_pkg` holds:
  - `aluc` opcode localparams (ALU_ADDU … ALU_SRL);
  - `md_op` codes;
  - the MDU state enum (IDLE, MUL, DIV, FIX).
- Sub-module `mdu_core` holds the FSM, iteration counter, shift/accumulate registers and sign fix. It is parametrised by WIDTH.
- Top `alu_mdu` contains the combinational ALU and instantiates `mdu_core`.

## Test plan
- **ALU flags** (WIDTH=32):
  - ADDU FFFFFFFF+1 → r=0, zero=1, carry=1.
  - ADD 7FFFFFFF+1 → overflow=1, negative=1.
  - SLT a=−1, b=1 → r=1, negative=1, zero=0.
  - SRA a=40, b=80000000 → r=FFFFFFFF, carry=1.
  - SLL a=0 → carry=0.
- **MULT** a=−3, b=7, start at E0 → busy for 33 cycles; `done` after E33; hi=FFFFFFFF, lo=FFFFFFEB.
- **DIV** a=−7, b=2 → lo=FFFFFFFD (−3), hi=FFFFFFFF (−1). DIVU a=100, b=7 → lo=14, hi=2.
- **DIV by zero** a=5, b=0 → `done` after E1, lo=FFFFFFFF, hi=5, div_zero=1. A following DIVU with nonzero b clears div_zero.
- **Handshake**:
  - `start` pulsed during busy → ignored, single `done`.
  - `start` held high through `done` → second op accepted on the `done` cycle.
- **Reset mid-op**: `rst_n` low at iteration 10 → busy=0, hi=lo=0 immediately, no `done`. After release, a new MULTU 0xFFFF×0xFFFF gives lo=FFFE0001, hi=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: aluc opcodes, md_op codes, MDU FSM state encoding.
package alu_pkg;

  // ALU opcodes. LUI also covers 4'b1001 and SLL also covers 4'b1111;
  // the top folds those aliases onto these codes before decoding.
  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  // md_op codes: bit 1 selects divide, bit 0 selects signed.
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: WIDTH+1 cycles accept-to-done (1 cycle for divide by zero).
// Backpressure: none; start is ignored while busy, controller stalls on busy.
// Ports: clk, rst_n (async, active-low); start/md_op/a/b request;
//        hi/lo results, busy, done (1-cycle pulse), div_zero (sticky to next accept).
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] ph_q;      // product high / partial remainder
  logic [WIDTH-1:0] pl_q;      // multiplier-then-product low / dividend-then-quotient
  logic [CW-1:0]    cnt_q;
  logic             op_div_q;
  logic             neg_lo_q;  // negate product, or quotient
  logic             neg_hi_q;  // negate remainder
  logic             dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div_zero_q;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_trial;

  assign accept = (state_q == IDLE) && start;
  assign b_zero = (b == '0);
  assign mag_a  = (md_op[0] && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (md_op[0] && b[WIDTH-1]) ? -b : b;

  assign mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mcand_q} : '0);
  assign div_sh    = {ph_q, pl_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, mcand_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (md_op[1] && b_zero) state_d = FIX;  // no iteration for divide by zero
        else if (md_op[1])      state_d = DIV;
        else                    state_d = MUL;
      end
      MUL:  if (cnt_q == LAST) state_d = FIX;
      DIV:  if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q    <= '0;
      ph_q       <= '0;
      pl_q       <= '0;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          cnt_q      <= '0;
          op_div_q   <= md_op[1];
          div_zero_q <= 1'b0;
          mcand_q    <= mag_b;
          if (md_op[1] && b_zero) begin
            // Preload the divide-by-zero result so FIX passes it straight through.
            dz_q     <= 1'b1;
            ph_q     <= a;
            pl_q     <= '1;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
          end else begin
            dz_q     <= 1'b0;
            ph_q     <= '0;
            pl_q     <= mag_a;
            neg_lo_q <= md_op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            // Remainder follows the dividend's sign.
            neg_hi_q <= md_op[0] && md_op[1] && a[WIDTH-1];
          end
        end
        MUL: begin
          // Shift {carry, sum, multiplier} right one; product bits fill pl from the top.
          ph_q  <= mul_sum[WIDTH:1];
          pl_q  <= {mul_sum[0], pl_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        DIV: begin
          // A borrow out of the trial subtract means restore (keep the shifted value).
          if (!div_trial[WIDTH]) begin
            ph_q <= div_trial[WIDTH-1:0];
            pl_q <= {pl_q[WIDTH-2:0], 1'b1};
          end else begin
            ph_q <= div_sh[WIDTH-1:0];
            pl_q <= {pl_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          if (op_div_q) begin
            lo_q <= neg_lo_q ? -pl_q : pl_q;
            hi_q <= neg_hi_q ? -ph_q : ph_q;
          end else begin
            {hi_q, lo_q} <= neg_lo_q ? -{ph_q, pl_q} : {ph_q, pl_q};
          end
          div_zero_q <= dz_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU (combinational, aluc-coded) plus iterative multiply/divide unit.
// Latency: ALU 0 cycles; MDU WIDTH+1 cycles (1 for divide by zero).
// Backpressure: ALU none; MDU ignores start while busy.
// Ports: a/b/aluc -> r, zero/carry/negative/overflow; clk/rst_n/start/md_op ->
//        hi/lo/busy/done/div_zero.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  input  logic             start,
  input  logic [1:0]       md_op,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam int HW  = WIDTH / 2;
  localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

  logic [3:0]       op;
  logic [WIDTH:0]   sum, diff;
  logic             lts, ltu, eq;
  logic             sh_big;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sll_w, srl_w, sra_w;

  // Fold opcode aliases (100x -> LUI, 111x -> SLL).
  always_comb begin
    op = aluc;
    if (aluc[3:1] == 3'b100) op = ALU_LUI;
    if (aluc[3:1] == 3'b111) op = ALU_SLL;
  end

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign ltu    = diff[WIDTH];
  assign lts    = $signed(a) < $signed(b);
  assign eq     = (a == b);
  assign sh_big = (a >= WVAL);
  assign sh     = a[SHW-1:0];

  // One extra bit beside b catches the last bit shifted out; it stays 0 for sh==0.
  assign sll_w = {1'b0, b} << sh;
  assign srl_w = {b, 1'b0} >> sh;
  assign sra_w = $signed({b, 1'b0}) >>> sh;

  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADDU: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      ALU_ADD: begin
        r        = sum[WIDTH-1:0];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUBU: begin
        r     = diff[WIDTH-1:0];
        carry = ltu;
      end
      ALU_SUB: begin
        r        = diff[WIDTH-1:0];
        carry    = lts;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_LUI:  r = {b[HW-1:0], {HW{1'b0}}};
      ALU_SLTU: begin
        r     = {{(WIDTH-1){1'b0}}, ltu};
        carry = ltu;
      end
      ALU_SLT:  r = {{(WIDTH-1){1'b0}}, lts};
      ALU_SRA: begin
        if (sh_big) begin
          r     = {WIDTH{b[WIDTH-1]}};
          carry = b[WIDTH-1];
        end else begin
          {r, carry} = sra_w;
        end
      end
      ALU_SRL: if (!sh_big) {r, carry} = srl_w;
      ALU_SLL: if (!sh_big) {carry, r} = sll_w;
      default: r = '0;
    endcase
  end

  // SLT/SLTU report the compare through negative/zero instead of the result.
  always_comb begin
    negative = (op == ALU_SLT) ? lts : r[WIDTH-1];
    zero     = (op == ALU_SLT || op == ALU_SLTU) ? eq : (r == '0);
  end

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_mdu_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32: directed and random ALU vectors,
// directed and random MDU operations against an arithmetic reference model,
// handshake corner cases and reset mid-operation.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [3:0]  aluc;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] r, hi, lo;
  logic        zero, carry, negative, overflow;
  logic        busy, done, div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .aluc     (aluc),
    .start    (start),
    .md_op    (md_op),
    .r        (r),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ALU reference: signed/unsigned arithmetic on 64-bit integers.
  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] er, output logic ez, output logic ec,
                                  output logic en, output logic ev);
    longint sx, sy, s;
    longint unsigned ux, uy, u;
    int sh;
    logic [31:0] yv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    yv = y;
    sh = (ux < 32) ? int'(ux) : 0;
    er = '0; ec = 1'b0; ev = 1'b0;
    case (op)
      4'd0: begin u = ux + uy; er = 32'(u); ec = (u > 64'hFFFF_FFFF); end
      4'd2: begin s = sx + sy; er = 32'(s); ev = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin er = 32'(ux - uy); ec = (ux < uy); end
      4'd3: begin s = sx - sy; er = 32'(s); ec = (sx < sy);
                  ev = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd4: er = x & y;
      4'd5: er = x | y;
      4'd6: er = x ^ y;
      4'd7: er = ~(x | y);
      4'd8, 4'd9: er = 32'(uy << 16);
      4'd10: begin er = (ux < uy) ? 32'd1 : 32'd0; ec = (ux < uy); end
      4'd11: er = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: begin
        if (ux >= 32) begin er = yv[31] ? 32'hFFFF_FFFF : 32'h0; ec = yv[31]; end
        else if (sh == 0) er = y;
        else begin er = 32'(sy >>> sh); ec = yv[sh-1]; end
      end
      4'd13: begin
        if (ux >= 32) er = '0;
        else if (sh == 0) er = y;
        else begin er = 32'(uy >> sh); ec = yv[sh-1]; end
      end
      default: begin
        if (ux >= 32) er = '0;
        else if (sh == 0) er = y;
        else begin er = 32'(uy << sh); ec = yv[32-sh]; end
      end
    endcase
    en = (op == 4'd11) ? (sx < sy) : er[31];
    ez = (op == 4'd10 || op == 4'd11) ? (x == y) : (er == 32'h0);
  endfunction

  // MDU reference: full-width products, truncating divide from the language operators.
  function automatic void md_ref(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, m;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (op == 2'd0) begin
      p = ux * uy; eh = p[63:32]; el = p[31:0];
    end else if (op == 2'd1) begin
      q = sx * sy; {eh, el} = q;
    end else if (y == 32'h0) begin
      el = 32'hFFFF_FFFF; eh = x;
    end else if (op == 2'd2) begin
      el = 32'(ux / uy); eh = 32'(ux % uy);
    end else begin
      q = sx / sy; m = sx % sy; el = 32'(q); eh = 32'(m);
    end
  endfunction

  task automatic alu_lit(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er,
                         input logic ez, input logic ec, input logic en, input logic ev);
    aluc = op; a = x; b = y;
    #1;
    chk({tag, ".r"}, r, er);
    chk({tag, ".zcnv"}, {zero, carry, negative, overflow}, {ez, ec, en, ev});
  endtask

  task automatic alu_rand(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y);
    logic [31:0] er;
    logic ez, ec, en, ev;
    alu_ref(op, x, y, er, ez, ec, en, ev);
    aluc = op; a = x; b = y;
    #1;
    chk(tag, {r, zero, carry, negative, overflow}, {er, ez, ec, en, ev});
  endtask

  // Drive a request so it is sampled on the next rising edge (E0).
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit hold);
    @(negedge clk);
    md_op = op; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("accept.busy", busy, 1'b1);
    chk("accept.done", done, 1'b0);
  endtask

  // Count edges until done shows; an expired budget reports as a latency mismatch.
  task automatic wait_done(input string tag, input int exp_lat);
    int k = 0;
    bit seen = 0;
    while (k < 60 && !seen) begin
      @(posedge clk);
      #1;
      k++;
      if (done) seen = 1;
    end
    if (!seen) k = 999;
    chk({tag, ".lat"}, k, exp_lat);
    chk({tag, ".busy_at_done"}, busy, 1'b0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    chk({tag, ".div_zero"}, div_zero, edz);
  endtask

  task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    logic edz;
    edz = op[1] && (y == 32'h0);
    issue(op, x, y, 0);
    wait_done(tag, edz ? 1 : 33);
    check_res(tag, eh, el, edz);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh, el;
    logic [1:0]  op;
    logic [31:0] x, y;
    int dones;

    rst_n = 1'b0; start = 1'b0; md_op = 2'd0; a = '0; b = '0; aluc = 4'd0;
    #12;
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);
    chk("rst.flags", {busy, done, div_zero}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed ALU vectors
    alu_lit("addu_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, 0, 0);
    alu_lit("add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 1);
    alu_lit("slt_neg",   4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 1, 0);
    alu_lit("sra_big",   4'b1100, 32'd40, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1, 0);
    alu_lit("sll_zero",  4'b1110, 32'd0, 32'h1234_5678, 32'h1234_5678, 0, 0, 0, 0);
    alu_lit("subu_brw",  4'b0001, 32'd1, 32'd2, 32'hFFFF_FFFF, 0, 1, 1, 0);
    alu_lit("srl_4",     4'b1101, 32'd4, 32'h18, 32'h1, 0, 1, 0, 0);
    alu_lit("sll_1",     4'b1111, 32'd1, 32'h8000_0001, 32'h2, 0, 1, 0, 0);
    alu_lit("lui_alias", 4'b1001, 32'h0, 32'h0000_ABCD, 32'hABCD_0000, 0, 0, 1, 0);
    alu_lit("sltu_eq",   4'b1010, 32'h55, 32'h55, 32'h0, 1, 0, 0, 0);
    alu_lit("sub_ovf",   4'b0011, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 0, 1);

    // Random ALU vectors; shift amounts biased toward the interesting range.
    for (int i = 0; i < 300; i++) begin
      x = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      alu_rand("alu_rand", 4'($urandom_range(0, 15)), x, y);
    end

    // Directed MDU operations
    run_md("mult",     2'b01, 32'hFFFF_FFFD, 32'd7,   32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("div_neg",  2'b11, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",     2'b10, 32'd100,       32'd7,   32'd2,         32'd14);
    run_md("div_zero", 2'b11, 32'd5,         32'd0,   32'd5,         32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("dz_sticky", div_zero, 1'b1);
    run_md("dz_clear", 2'b10, 32'd9,         32'd3,   32'd0,         32'd3);
    run_md("min_m1",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,   32'h8000_0000);

    // Random MDU operations
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      md_ref(op, x, y, eh, el);
      run_md("md_rand", op, x, y, eh, el);
    end

    // start pulsed while busy must be ignored
    issue(2'b00, 32'd1234, 32'd5678, 0);
    repeat (3) begin @(posedge clk); #1; end
    md_op = 2'b11; a = 32'd9; b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign_start", 29);
    check_res("ign_start", 32'd0, 32'd7006652, 1'b0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("ign_start.extra_done", dones, 0);

    // start held through done: second op accepted on the done cycle
    issue(2'b10, 32'd1000, 32'd30, 1);
    md_op = 2'b01; a = 32'hFFFF_FFFE; b = 32'd21;
    wait_done("b2b_first", 33);
    check_res("b2b_first", 32'd10, 32'd33, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b.accept_busy", busy, 1'b1);
    wait_done("b2b_second", 33);
    check_res("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);

    // Reset in the middle of an operation
    issue(2'b00, 32'd77, 32'd88, 0);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", busy, 1'b0);
    chk("rst_mid.hi", hi, 32'h0);
    chk("rst_mid.lo", lo, 32'h0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("rst_mid.done", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_md("post_rst", 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 32'hFFFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
